// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer output sequencer.
package layer_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Index width, never less than one bit so NN==1 still has a legal counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_sequencer_argmax.sv
// Signed running arg-max over one streamed inference; ties keep the lower index.
module seq_argmax
    import layer_seq_pkg::*;
#(
    parameter int dataWidth = 16,
    parameter int CNT_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic                        last_i,
    input  logic signed [dataWidth-1:0] data_i,
    input  logic [CNT_W-1:0]            idx_i,
    output logic [CNT_W-1:0]            max_idx_o,
    output logic                        max_valid_o
);

    logic signed [dataWidth-1:0] best_q;
    logic [CNT_W-1:0]            best_idx_q;
    logic [CNT_W-1:0]            max_idx_q;
    logic                        max_valid_q;
    logic                        take;
    logic [CNT_W-1:0]            win_idx;

    // Word 0 always seeds the tracker, so no clearing is needed between inferences.
    assign take    = valid_i & ((idx_i == '0) | (data_i > best_q));
    assign win_idx = take ? idx_i : best_idx_q;

    always_ff @(posedge clk) begin
        if (take) begin
            best_q <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx_q  <= '0;
            max_idx_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            if (take) begin
                best_idx_q <= idx_i;
            end
            max_valid_q <= valid_i & last_i;
            if (valid_i & last_i) begin
                max_idx_q <= win_idx;
            end
        end
    end

    assign max_idx_o   = max_idx_q;
    assign max_valid_o = max_valid_q;

endmodule

// File: rtl/layer_out_sequencer.sv
// Buffers one layer's parallel outputs and streams them word by word to the next layer.
// Optional arg-max tracking on the stream is enabled with `define LAYER_SEQ_ARGMAX_EN.
module layer_out_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    input  logic                    o_ready,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last,
    output logic                    o_busy,
`ifdef LAYER_SEQ_ARGMAX_EN
    output logic [cnt_width(NN)-1:0] o_max_idx,
    output logic                     o_max_valid,
`endif
    output logic                    o_overrun
);

    localparam int               CNT_W    = cnt_width(NN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN - 1);

    typedef logic signed [dataWidth-1:0] word_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    word_t            buf_q [NN];
    word_t            cur_word;
    logic             trig, hs, at_last, load;
    logic             unused_valid_bits;

    // All neurons of a layer finish together, so neuron 0 stands in for the whole layer.
    assign trig              = i_valid[0];
    assign unused_valid_bits = ^i_valid;
    assign at_last           = (idx_q == LAST_IDX);
    assign hs                = o_valid & o_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (hs && at_last) begin
                    idx_d = '0;
                    if (trig) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx_q + 1'b1;
                    end
                    // Buffer still in use: the new layer result is lost.
                    if (trig) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NN; k++) begin
                buf_q[k] <= i_data[k*dataWidth +: dataWidth];
            end
        end
    end

    assign cur_word  = buf_q[idx_q];
    assign o_valid   = (state_q == SHIFT);
    assign o_busy    = (state_q == SHIFT);
    assign o_last    = o_valid & at_last;
    assign o_data    = o_valid ? cur_word : '0;
    assign o_overrun = overrun_q;

`ifdef LAYER_SEQ_ARGMAX_EN
    seq_argmax #(
        .dataWidth (dataWidth),
        .CNT_W     (CNT_W)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (hs),
        .last_i      (at_last),
        .data_i      (cur_word),
        .idx_i       (idx_q),
        .max_idx_o   (o_max_idx),
        .max_valid_o (o_max_valid)
    );
`endif

endmodule
